// File: rtl/draw_sched_pkg.sv
// Shared state encoding and draw-core command codes
// for the draw command scheduler.
package draw_sched_pkg;

  localparam int IDX_W = 4;
  localparam int PTR_W = 5;

  typedef enum logic [2:0] {
    S_BOOT,
    S_INIT,
    S_SCAN,
    S_ISSUE,
    S_WAIT,
    S_RELEASE
  } sched_state_t;

  typedef enum logic [3:0] {
    CMD_CLEAR     = 4'd0,
    CMD_FIXED_IMG = 4'd1,
    CMD_RTC       = 4'd2,
    CMD_SIN       = 4'd3,
    CMD_SYNC      = 4'd4,
    CMD_PULSE     = 4'd5,
    CMD_HIST      = 4'd6,
    CMD_PERIOD    = 4'd7,
    CMD_ACCUM     = 4'd8,
    CMD_GAIN_TI   = 4'd9,
    CMD_MINMAX    = 4'd10
  } draw_cmd_t;

endpackage

// File: rtl/draw_slot_picker.sv
// Find-first-set over eligible slots at or above the scan pointer.
// Lowest qualifying index wins.
module draw_slot_picker
  import draw_sched_pkg::*;
#(
  parameter int NUM_SLOTS = 8
) (
  input  logic [NUM_SLOTS-1:0] i_elig,
  input  logic [PTR_W-1:0]     i_ptr,
  output logic                 o_hit,
  output logic [IDX_W-1:0]     o_idx
);

  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (i_elig[k] && (PTR_W'(k) >= i_ptr)) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/draw_cmd_scheduler.sv
// Draw-command sequencer: one-shot init slots, then framed scans
// of the remaining slots with an en/done handshake and watchdog.
module draw_cmd_scheduler
  import draw_sched_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int CMD_W = 4,
  parameter int DATA_W = 32,
  parameter int INIT_SLOTS = 3,
  parameter logic [NUM_SLOTS-1:0] ALWAYS_MASK = NUM_SLOTS'(6),
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [NUM_SLOTS*CMD_W-1:0]  slot_cmd_i,
  input  logic [NUM_SLOTS*DATA_W-1:0] slot_data1_i,
  input  logic [NUM_SLOTS*DATA_W-1:0] slot_data2_i,
  input  logic [NUM_SLOTS-1:0]        slot_enable_i,
  input  logic [NUM_SLOTS-1:0]        slot_dirty_i,
  input  logic                        force_refresh_i,
  output logic                        core_en_o,
  output logic [CMD_W-1:0]            core_cmd_o,
  output logic [DATA_W-1:0]           core_data1_o,
  output logic [DATA_W-1:0]           core_data2_o,
  input  logic                        core_done_i,
  output logic                        busy_o,
  output logic [3:0]                  cur_slot_o,
  output logic                        frame_done_o,
  output logic                        timeout_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [PTR_W-1:0] PTR_FIRST = PTR_W'(INIT_SLOTS);
  localparam logic [NUM_SLOTS-1:0] SCAN_RANGE =
    ~NUM_SLOTS'((1 << INIT_SLOTS) - 1);

  sched_state_t          r_state;
  logic [PTR_W-1:0]      r_ptr;
  logic [PTR_W-1:0]      r_init_idx;
  logic [IDX_W-1:0]      r_slot;
  logic [NUM_SLOTS-1:0]  r_pending;
  logic [WD_W-1:0]       r_wdog;
  logic                  r_core_en;
  logic                  r_busy;
  logic [CMD_W-1:0]      r_cmd;
  logic [DATA_W-1:0]     r_d1;
  logic [DATA_W-1:0]     r_d2;
  logic                  r_frame_done;
  logic                  r_timeout;

  logic [NUM_SLOTS-1:0]  w_elig;
  logic [NUM_SLOTS-1:0]  w_onehot;
  logic [NUM_SLOTS-1:0]  w_clr;
  logic [NUM_SLOTS-1:0]  w_set;
  logic                  w_tmo;
  logic                  w_hit;
  logic [IDX_W-1:0]      w_idx;

  assign w_elig   = slot_enable_i & (r_pending | ALWAYS_MASK) & SCAN_RANGE;
  assign w_onehot = NUM_SLOTS'(1) << r_slot;
  assign w_clr    = (r_state == S_ISSUE) ? w_onehot : '0;
  assign w_tmo    = (r_state == S_WAIT) && !core_done_i
                    && (r_wdog == WD_LAST);
  assign w_set    = slot_dirty_i | {NUM_SLOTS{force_refresh_i}}
                    | (w_tmo ? w_onehot : '0);

  draw_slot_picker #(
    .NUM_SLOTS(NUM_SLOTS)
  ) u_picker (
    .i_elig(w_elig),
    .i_ptr (r_ptr),
    .o_hit (w_hit),
    .o_idx (w_idx)
  );

  // Sets are applied after the clear so a mid-flight dirty survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '1;
    else        r_pending <= (r_pending & ~w_clr) | w_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_BOOT;
      r_ptr        <= PTR_FIRST;
      r_init_idx   <= '0;
      r_slot       <= '0;
      r_wdog       <= '0;
      r_core_en    <= 1'b0;
      r_busy       <= 1'b0;
      r_cmd        <= '0;
      r_d1         <= '0;
      r_d2         <= '0;
      r_frame_done <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_timeout    <= 1'b0;
      unique case (r_state)
        S_BOOT: r_state <= S_INIT;
        S_INIT: begin
          if (en) begin
            if (r_init_idx == PTR_FIRST) begin
              r_state <= S_SCAN;
            end else begin
              r_slot  <= r_init_idx[IDX_W-1:0];
              r_state <= S_ISSUE;
            end
          end
        end
        S_SCAN: begin
          if (en) begin
            if (w_hit) begin
              r_slot  <= w_idx;
              r_ptr   <= PTR_W'(w_idx) + PTR_W'(1);
              r_state <= S_ISSUE;
            end else begin
              r_frame_done <= 1'b1;
              r_ptr        <= PTR_FIRST;
            end
          end
        end
        S_ISSUE: begin
          r_cmd     <= slot_cmd_i[int'(r_slot)*CMD_W +: CMD_W];
          r_d1      <= slot_data1_i[int'(r_slot)*DATA_W +: DATA_W];
          r_d2      <= slot_data2_i[int'(r_slot)*DATA_W +: DATA_W];
          r_core_en <= 1'b1;
          r_busy    <= 1'b1;
          r_wdog    <= WD_W'(1);
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done_i || w_tmo) begin
            r_timeout <= w_tmo;
            r_core_en <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= S_RELEASE;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
        end
        S_RELEASE: begin
          if (r_init_idx != PTR_FIRST) begin
            r_init_idx <= r_init_idx + PTR_W'(1);
            r_state    <= S_INIT;
          end else begin
            r_state <= S_SCAN;
          end
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign core_en_o    = r_core_en;
  assign core_cmd_o   = r_cmd;
  assign core_data1_o = r_d1;
  assign core_data2_o = r_d2;
  assign busy_o       = r_busy;
  assign cur_slot_o   = r_slot;
  assign frame_done_o = r_frame_done;
  assign timeout_o    = r_timeout;

endmodule

// File: tb/tb_draw_cmd_scheduler.sv
// Directed-sequence bench with random slot contents, checked against
// a frame-level model of which slots each pass must issue.
module tb_draw_cmd_scheduler;

  localparam int NS = 8;
  localparam int CW = 4;
  localparam int DW = 32;
  localparam int TMO = 64;
  localparam logic [NS-1:0] AMASK = 8'h30;

  typedef struct {
    int           slot;
    int           frame;
    logic [CW-1:0] cmd;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
  } rec_t;

  logic clk, rst_n, en;
  logic [NS*CW-1:0] slot_cmd_i;
  logic [NS*DW-1:0] slot_data1_i, slot_data2_i;
  logic [NS-1:0] slot_enable_i, slot_dirty_i;
  logic force_refresh_i;
  logic core_en_o, core_done_i, busy_o, frame_done_o, timeout_o;
  logic [CW-1:0] core_cmd_o;
  logic [DW-1:0] core_data1_o, core_data2_o;
  logic [3:0] cur_slot_o;

  draw_cmd_scheduler #(
    .NUM_SLOTS(NS), .CMD_W(CW), .DATA_W(DW), .INIT_SLOTS(3),
    .ALWAYS_MASK(AMASK), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .slot_cmd_i(slot_cmd_i), .slot_data1_i(slot_data1_i),
    .slot_data2_i(slot_data2_i), .slot_enable_i(slot_enable_i),
    .slot_dirty_i(slot_dirty_i), .force_refresh_i(force_refresh_i),
    .core_en_o(core_en_o), .core_cmd_o(core_cmd_o),
    .core_data1_o(core_data1_o), .core_data2_o(core_data2_o),
    .core_done_i(core_done_i), .busy_o(busy_o),
    .cur_slot_o(cur_slot_o), .frame_done_o(frame_done_o),
    .timeout_o(timeout_o)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  int checks = 0, errors = 0;
  rec_t iss_q[$], exp_q[$];
  int frame_cnt = 0, tmo_cnt = 0, tmo_len = 0, tmo_slot = 0;
  int busy_bad = 0, unstable = 0, en_len = 0;
  logic tmo_en = 0, prev_en = 0;
  logic [DW-1:0] d1_hold = '0;
  logic nores = 0;
  int lat = 0;

  logic [CW-1:0] m_cmd [NS];
  logic [DW-1:0] m_d1 [NS];
  logic [DW-1:0] m_d2 [NS];
  logic [NS-1:0] m_pend, m_en;
  int base, f0, t0, c;
  logic [DW-1:0] old6;

  // Observer: records each issue with the frame count at that moment.
  initial forever begin
    rec_t r;
    @(posedge clk); #1;
    if (frame_done_o) frame_cnt++;
    if (core_en_o && !prev_en) begin
      r.slot = int'(cur_slot_o); r.frame = frame_cnt;
      r.cmd = core_cmd_o; r.d1 = core_data1_o; r.d2 = core_data2_o;
      iss_q.push_back(r);
      en_len = 0; d1_hold = core_data1_o;
    end
    if (core_en_o) begin
      en_len++;
      if (core_data1_o !== d1_hold) unstable++;
    end
    if (busy_o !== core_en_o) busy_bad++;
    if (timeout_o) begin
      tmo_cnt++; tmo_len = en_len; tmo_en = core_en_o;
      tmo_slot = int'(cur_slot_o);
    end
    prev_en = core_en_o;
  end

  // Draw core: done 4 cycles after en, optionally silent for slot 7.
  initial begin
    core_done_i = 0;
    forever begin
      @(posedge clk); #1;
      if (core_en_o && !(nores && cur_slot_o == 4'd7)) begin
        lat++;
        core_done_i = (lat >= 4);
      end else begin
        lat = 0;
        core_done_i = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NS; k++) begin
      slot_cmd_i[k*CW +: CW] = m_cmd[k];
      slot_data1_i[k*DW +: DW] = m_d1[k];
      slot_data2_i[k*DW +: DW] = m_d2[k];
    end
  endtask

  task automatic mark();
    base = iss_q.size();
    f0 = frame_cnt;
  endtask

  task automatic push_exp(input int k, input int f);
    rec_t r;
    r.slot = k; r.frame = f; r.cmd = m_cmd[k];
    r.d1 = m_d1[k]; r.d2 = m_d2[k];
    exp_q.push_back(r);
  endtask

  task automatic model_init();
    for (int k = 0; k < 3; k++) begin
      push_exp(k, 0);
      m_pend[k] = 0;
    end
  endtask

  task automatic model_frame(input int f);
    for (int k = 3; k < NS; k++)
      if (m_en[k] && (m_pend[k] || AMASK[k])) begin
        push_exp(k, f);
        m_pend[k] = 0;
      end
  endtask

  task automatic compare(input string tag);
    int n;
    n = iss_q.size() - base;
    chk({tag, "_count"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      rec_t a, e;
      a = iss_q[base+i]; e = exp_q[i];
      chk({tag, "_frame_slot"}, {a.frame - f0, a.slot}, {e.frame, e.slot});
      chk({tag, "_cmd_d1"}, {a.cmd, a.d1}, {e.cmd, e.d1});
      chk({tag, "_d2"}, a.d2, e.d2);
    end
    exp_q.delete();
  endtask

  task automatic wait_frames(input int n);
    c = 0;
    while (frame_cnt - f0 < n && c < 3000) begin
      @(negedge clk); c++;
    end
    chk("frame_wait", 64'(frame_cnt - f0 >= n), 1);
    en = 0;
  endtask

  task automatic wait_issues(input int n);
    c = 0;
    while (iss_q.size() - base < n && c < 1000) begin
      @(negedge clk); c++;
    end
    chk("issue_wait", 64'(iss_q.size() - base >= n), 1);
  endtask

  initial begin
    rst_n = 1; en = 1; nores = 0;
    slot_enable_i = '0; slot_dirty_i = '0; force_refresh_i = 0;
    for (int k = 0; k < NS; k++) begin
      m_cmd[k] = CW'($urandom); m_d1[k] = $urandom; m_d2[k] = $urandom;
    end
    drive();
    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_core_en", core_en_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_cur_slot", cur_slot_o, 0);
    chk("rst_frame_done", frame_done_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_cmd_data", {core_cmd_o, core_data1_o, core_data2_o}, 0);

    // Init: slots 0..2 once, then empty passes with no slot enabled.
    m_pend = '1;
    mark(); model_init();
    rst_n = 1;
    wait_issues(3);
    repeat (20) @(negedge clk);
    compare("init");
    chk("empty_frames_pulse", 64'(frame_cnt - f0 > 2), 1);

    // Random enables; pending from reset plus always-refresh slots.
    m_en = 8'($urandom) | AMASK;
    slot_enable_i = m_en;
    mark();
    model_frame(0); model_frame(1); model_frame(2);
    wait_frames(3);
    compare("frames");

    // Dirty on slot 6 while it is in flight.
    m_en = 8'hF8; slot_enable_i = m_en;
    slot_dirty_i = 8'h40;
    @(negedge clk);
    slot_dirty_i = '0; m_pend[6] = 1;
    old6 = m_d1[6];
    mark(); en = 1;
    model_frame(0);
    m_d1[6] = 32'h1234; m_pend[6] = 1;
    model_frame(1); model_frame(2);
    c = 0;
    while (!(core_en_o && cur_slot_o == 4'd6) && c < 1000) begin
      @(negedge clk); c++;
    end
    chk("reach_slot6", 64'(core_en_o && cur_slot_o == 4'd6), 1);
    slot_dirty_i = 8'h40; drive();
    @(negedge clk);
    slot_dirty_i = '0;
    chk("slot6_latched_d1", core_data1_o, old6);
    chk("slot6_still_en", core_en_o, 1);
    wait_frames(3);
    compare("dirty");

    // Watchdog on slot 7: core never answers the first time.
    slot_dirty_i = 8'h80;
    @(negedge clk);
    slot_dirty_i = '0; m_pend[7] = 1;
    nores = 1; t0 = tmo_cnt;
    mark(); en = 1;
    model_frame(0); m_pend[7] = 1; model_frame(1); model_frame(2);
    c = 0;
    while (tmo_cnt == t0 && c < 1000) begin
      @(negedge clk); c++;
    end
    nores = 0;
    chk("tmo_count", 64'(tmo_cnt - t0), 1);
    chk("tmo_en_high_len", 64'(tmo_len), TMO - 1);
    chk("tmo_core_en_dropped", tmo_en, 0);
    chk("tmo_slot", 64'(tmo_slot), 7);
    chk("tmo_busy", busy_o, 0);
    wait_frames(3);
    compare("timeout");

    // Drop en mid-command, then resume from the saved pointer.
    mark(); en = 1;
    model_frame(0); model_frame(1);
    wait_issues(1);
    en = 0;
    repeat (30) @(negedge clk);
    chk("hold_issues", 64'(iss_q.size() - base), 1);
    chk("hold_frames", 64'(frame_cnt - f0), 0);
    chk("hold_core_en", core_en_o, 0);
    chk("hold_busy", busy_o, 0);
    en = 1;
    wait_frames(2);
    compare("resume");

    // Reset mid-command: core_en drops at once, init replays.
    en = 1;
    c = 0;
    while (!core_en_o && c < 1000) begin
      @(negedge clk); c++;
    end
    chk("pre_rst_core_en", core_en_o, 1);
    rst_n = 0;
    #1;
    chk("midrst_core_en", core_en_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_cur_slot", cur_slot_o, 0);
    m_pend = '1;
    mark(); model_init();
    @(negedge clk);
    rst_n = 1;
    wait_issues(3);
    en = 0;
    repeat (10) @(negedge clk);
    compare("replay");

    chk("busy_tracks_core_en", 64'(busy_bad), 0);
    chk("operands_stable", 64'(unstable), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
